// File: rtl/starfield_parallax.sv
// Parallax starfield generator: VGA timing plus LAYERS independent 16-bit
// Galois-LFSR star layers that scroll left at per-layer speeds.
// All outputs are registered and describe the counter state of the
// previous clock.
module starfield_parallax #(
  parameter int                   H_ACTIVE    = 640,
  parameter int                   H_FP        = 24,
  parameter int                   H_SYNC      = 40,
  parameter int                   H_BP        = 128,
  parameter int                   V_ACTIVE    = 480,
  parameter int                   V_FP        = 9,
  parameter int                   V_SYNC      = 3,
  parameter int                   V_BP        = 28,
  parameter int                   LAYERS      = 3,
  parameter int                   SPEED       = 1,
  parameter int                   DENS_BITS   = 6,
  parameter logic [15:0]          SEED        = 16'hACE1,
  parameter logic [3*LAYERS-1:0]  LAYER_COLOR = 9'b111_011_001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       frame_start,
  output logic [2:0] rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int ADV_W   = $clog2(LAYERS * SPEED + 1);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_VIS_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_BEGIN   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_VIS_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_BEGIN   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Every scheduled advance step must fit in the vertical blanking window,
  // otherwise frames would silently lose scroll distance.
  if (LAYERS < 1 || LAYERS > 8) begin : g_bad_layers
    $fatal(1, "starfield_parallax: LAYERS must be 1..8");
  end
  if (LAYERS * SPEED >= (V_FP + V_SYNC + V_BP) * H_TOTAL) begin : g_bad_speed
    $fatal(1, "starfield_parallax: LAYERS*SPEED exceeds the vertical blanking window");
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {1'b0, x[15:1]} ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] layer_seed(input int i);
    logic [15:0] s;
    s = SEED + 16'(i * 32'h1F35);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  logic [HW-1:0]    hcount;
  logic [VW-1:0]    vcount;
  logic [15:0]      f_state   [LAYERS];
  logic [15:0]      l_state   [LAYERS];
  logic [15:0]      cur_state [LAYERS];
  logic [ADV_W-1:0] adv       [LAYERS];
  logic [LAYERS-1:0] star;
  logic [2:0]       pixel;
  logic             visible;
  logic             at_origin;
  logic             last_visible;

  assign visible      = (hcount < H_VIS) && (vcount < V_VIS);
  assign at_origin    = (hcount == '0) && (vcount == '0);
  assign last_visible = (hcount == H_VIS_LAST) && (vcount == V_VIS_LAST);

  // Raster counters: hcount wraps each line, vcount wraps each frame.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
    end else begin
      hcount <= hcount + 1'b1;
    end
  end

  // Star detection per layer and highest-index-wins colour selection.
  // At (0,0) the working LFSR is bypassed by the frame-start state so the
  // first pixel of a frame already sees the reloaded value.
  // NOTE: every variable gets a default before the conditional logic so no
  // latch is inferred.
  always_comb begin
    pixel = 3'b000;
    star  = '0;
    for (int i = 0; i < LAYERS; i++) begin
      cur_state[i] = at_origin ? f_state[i] : l_state[i];
      star[i]      = &cur_state[i][DENS_BITS-1:0];
      if (star[i]) pixel = LAYER_COLOR[3*i +: 3];
    end
  end

  // Layer state: working LFSRs step per visible pixel; frame-start LFSRs
  // step adv times in the blanking after the last visible pixel.
  // NOTE: the per-layer state arrays are a handful of registers, not a RAM,
  // so they are reset explicitly to their seeds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAYERS; i++) begin
        f_state[i] <= layer_seed(i);
        l_state[i] <= layer_seed(i);
        adv[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < LAYERS; i++) begin
        if (visible) l_state[i] <= lfsr_step(cur_state[i]);
        if (at_origin) begin
          adv[i] <= '0;
        end else if (last_visible) begin
          adv[i] <= ADV_W'((i + 1) * SPEED);
        end else if (adv[i] != '0 && !pause) begin
          f_state[i] <= lfsr_step(f_state[i]);
          adv[i]     <= adv[i] - 1'b1;
        end
      end
    end
  end

  // Registered video outputs, one clock behind the counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      frame_start <= 1'b0;
      rgb         <= 3'b000;
    end else begin
      hsync       <= !((hcount >= HS_BEGIN) && (hcount < HS_END));
      vsync       <= !((vcount >= VS_BEGIN) && (vcount < VS_END));
      de          <= visible;
      frame_start <= at_origin;
      rgb         <= visible ? pixel : 3'b000;
    end
  end

endmodule

// File: tb/tb_starfield_parallax.sv
// Bench for starfield_parallax using a reduced 24x12 mode and three
// configurations: 3 layers/speed 1, 3 layers/speed 4 with dense overlapping
// stars, and a single dense layer for the raw LFSR sequence.
module tb_starfield_parallax;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
  localparam int HT    = HA + HF + HS + HB;
  localparam int VT    = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int NPIX  = HA * VA;

  logic clk = 1'b0;
  logic reset;
  logic pause;

  logic hsync_a, vsync_a, de_a, fs_a;  logic [2:0] rgb_a;
  logic hsync_b, vsync_b, de_b, fs_b;  logic [2:0] rgb_b;
  logic hsync_c, vsync_c, de_c, fs_c;  logic [2:0] rgb_c;

  always #5 clk = ~clk;

  starfield_parallax #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .LAYERS(3), .SPEED(1), .DENS_BITS(2)) dut_a (
    .clk(clk), .reset(reset), .pause(pause), .hsync(hsync_a), .vsync(vsync_a),
    .de(de_a), .frame_start(fs_a), .rgb(rgb_a));

  starfield_parallax #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .LAYERS(3), .SPEED(4), .DENS_BITS(1)) dut_b (
    .clk(clk), .reset(reset), .pause(pause), .hsync(hsync_b), .vsync(vsync_b),
    .de(de_b), .frame_start(fs_b), .rgb(rgb_b));

  starfield_parallax #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .LAYERS(1), .SPEED(1), .DENS_BITS(1), .LAYER_COLOR(3'b101)) dut_c (
    .clk(clk), .reset(reset), .pause(pause), .hsync(hsync_c), .vsync(vsync_c),
    .de(de_c), .frame_start(fs_c), .rgb(rgb_c));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] step16(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] seed_of(input int i);
    logic [15:0] s;
    s = 16'hACE1 + 16'(i * 16'h1F35);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  int          lay [3] = '{3, 3, 1};
  int          spd [3] = '{1, 4, 1};
  logic [15:0] msk [3] = '{16'h0003, 16'h0001, 16'h0001};
  logic [23:0] col [3] = '{24'b111_011_001, 24'b111_011_001, 24'b101};
  logic [15:0] fst [3][8];

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] c;
  } pix_t;
  pix_t q[$];

  task automatic model_reset();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 8; i++) fst[d][i] = seed_of(i);
  endtask

  task automatic model_advance();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < lay[d]; i++)
        for (int s = 0; s < (i + 1) * spd[d]; s++) fst[d][i] = step16(fst[d][i]);
  endtask

  // Push the expected colour of every visible pixel of the frame just begun.
  task automatic push_frame();
    logic [15:0] w [3][8];
    logic [2:0]  c [3];
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 8; i++) w[d][i] = fst[d][i];
    for (int p = 0; p < NPIX; p++) begin
      for (int d = 0; d < 3; d++) begin
        c[d] = 3'b000;
        for (int i = 0; i < lay[d]; i++)
          if ((w[d][i] & msk[d]) == msk[d]) c[d] = col[d][3*i +: 3];
        for (int i = 0; i < lay[d]; i++) w[d][i] = step16(w[d][i]);
      end
      q.push_back('{a: c[0], b: c[1], c: c[2]});
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  int   mism [3];
  int   tpos;
  int   frame_no = 0;
  logic in_frame = 1'b0;
  logic win_paused = 1'b0;

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        in_frame   = 1'b0;
        win_paused = 1'b0;
        model_reset();
      end else begin
        if (fs_a) begin
          if (in_frame) begin
            for (int d = 0; d < 3; d++)
              check($sformatf("frame%0d dut%0d pixel errors", frame_no, d), mism[d], 0);
            check($sformatf("frame%0d leftover pixels", frame_no), q.size(), 0);
            q.delete();
            if (!win_paused) model_advance();
            frame_no++;
          end
          in_frame = 1'b1;
          tpos     = 0;
          for (int d = 0; d < 3; d++) mism[d] = 0;
          push_frame();
        end else if (in_frame) begin
          tpos++;
        end
        if (in_frame && tpos == VA * HT) win_paused = pause;
        if (in_frame) begin
          if (de_a) begin
            if (q.size() == 0) begin
              for (int d = 0; d < 3; d++) mism[d]++;
            end else begin
              pix_t e;
              e = q.pop_front();
              if (rgb_a !== e.a) mism[0]++;
              if (rgb_b !== e.b) mism[1]++;
              if (rgb_c !== e.c) mism[2]++;
            end
          end else begin
            if (rgb_a !== 3'b000) mism[0]++;
            if (rgb_b !== 3'b000) mism[1]++;
            if (rgb_c !== 3'b000) mism[2]++;
          end
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  typedef struct {
    int         t;
    logic       pause;
    logic [3:0] sync;     // {hsync, vsync, de, frame_start}
    logic       chk_rgb;
    logic [2:0] rgb_c;
  } vec_t;
  vec_t vecs [19];

  task automatic wait_fs(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fs_a !== 1'b1 && n < 2 * FRAME);
    check({nm, " frame_start seen"}, 32'(fs_a), 1);
    check({nm, " frame period"}, n, FRAME);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, " dut_a"}, {hsync_a, vsync_a, de_a, fs_a, rgb_a}, 7'b1100000);
    check({nm, " dut_b"}, {hsync_b, vsync_b, de_b, fs_b, rgb_b}, 7'b1100000);
    check({nm, " dut_c"}, {hsync_c, vsync_c, de_c, fs_c, rgb_c}, 7'b1100000);
  endtask

  initial begin
    int cur_t;
    vecs[0]  = '{0,   1'b0, 4'b1111, 1'b1, 3'b101};
    vecs[1]  = '{1,   1'b0, 4'b1110, 1'b1, 3'b000};
    vecs[2]  = '{2,   1'b0, 4'b1110, 1'b1, 3'b000};
    vecs[3]  = '{3,   1'b0, 4'b1110, 1'b1, 3'b000};
    vecs[4]  = '{15,  1'b0, 4'b1110, 1'b0, 3'b000};
    vecs[5]  = '{16,  1'b0, 4'b1100, 1'b0, 3'b000};
    vecs[6]  = '{17,  1'b0, 4'b1100, 1'b0, 3'b000};
    vecs[7]  = '{18,  1'b0, 4'b0100, 1'b0, 3'b000};
    vecs[8]  = '{20,  1'b0, 4'b0100, 1'b0, 3'b000};
    vecs[9]  = '{21,  1'b0, 4'b1100, 1'b0, 3'b000};
    vecs[10] = '{24,  1'b0, 4'b1110, 1'b0, 3'b000};
    vecs[11] = '{183, 1'b0, 4'b1110, 1'b0, 3'b000};
    vecs[12] = '{192, 1'b0, 4'b1100, 1'b0, 3'b000};
    vecs[13] = '{216, 1'b0, 4'b1000, 1'b0, 3'b000};
    vecs[14] = '{234, 1'b0, 4'b0000, 1'b0, 3'b000};
    vecs[15] = '{263, 1'b0, 4'b1000, 1'b0, 3'b000};
    vecs[16] = '{264, 1'b0, 4'b1100, 1'b0, 3'b000};
    vecs[17] = '{287, 1'b0, 4'b1100, 1'b0, 3'b000};
    vecs[18] = '{288, 1'b0, 4'b1111, 1'b0, 3'b000};

    reset = 1'b1;
    pause = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset state");
    reset = 1'b0;

    // First sample after release is pixel (0,0) of frame 0.
    @(negedge clk);
    check("lfsr l0 after 1 pixel", dut_c.l_state[0], 16'hE270);
    cur_t = 0;
    for (int k = 0; k < 19; k++) begin
      pause = vecs[k].pause;
      repeat (vecs[k].t - cur_t) @(negedge clk);
      cur_t = vecs[k].t;
      check($sformatf("sync t=%0d", vecs[k].t),
            {hsync_a, vsync_a, de_a, fs_a}, vecs[k].sync);
      if (vecs[k].chk_rgb)
        check($sformatf("lfsr rgb t=%0d", vecs[k].t), rgb_c, vecs[k].rgb_c);
    end

    // Frames 1..2 free-running, 3..5 paused windows, then resume.
    wait_fs("frame2");
    wait_fs("frame3");
    pause = 1'b1;
    wait_fs("frame4");
    wait_fs("frame5");
    wait_fs("frame6");
    pause = 1'b0;
    wait_fs("frame7");
    wait_fs("frame8");

    // Mid-frame reset at pixel (10,5); outputs must drop without a clock.
    repeat (5 * HT + 10) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("frame_start after release", 32'(fs_a), 1);
    wait_fs("frame after reset");
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
